regfile_mp: RTL and testbench

- Parametrised multi-port integer register file; next-generation replacement for the single-write, two-read core register file.
- Sits between decode and execute. Provides NUM_RD combinational read ports and two synchronous write ports (port 0 = ALU writeback, port 1 = load writeback).
- Adds hardwired x0, a reset-cleared array, a per-register busy scoreboard for multi-cycle producers, and optional same-cycle write-to-read bypass.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_scoreboard.sv | 43 ++++
 rtl/regfile_mp.sv | 88 ++++++++
 tb/tb_regfile_mp.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port integer register file.
// Consumers size their instances from these defaults unless overridden.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    typedef logic [XLEN_DEF-1:0]          word_t;
    typedef logic [$clog2(NREGS_DEF)-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one pending-producer flag per architectural register.
// Latency: set/clear take effect on the next rising edge; busy is a registered output.
// Backpressure: none; the scoreboard is advisory and never blocks issue or writeback.
module regfile_scoreboard #(
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_rd,
    input  logic             clr0_en,
    input  logic [AW-1:0]    clr0_addr,
    input  logic             clr1_en,
    input  logic [AW-1:0]    clr1_addr,
    output logic [NREGS-1:0] busy
);

    // Register 0 has no storage; it is hardwired not-busy.
    logic [NREGS-1:1] busy_q;
    logic [NREGS-1:1] busy_nxt;

    always_comb begin
        busy_nxt = busy_q;
        for (int r = 1; r < NREGS; r++) begin
            if ((clr0_en && clr0_addr == AW'(r)) || (clr1_en && clr1_addr == AW'(r)))
                busy_nxt[r] = 1'b0;
            // A new producer supersedes a completing older one.
            if (iss_en && iss_rd == AW'(r))
                busy_nxt[r] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy_q <= '0;
        else
            busy_q <= busy_nxt;
    end

    assign busy = {busy_q, 1'b0};

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational reads, two writes (port 1 wins), busy scoreboard.
// Latency: reads zero-cycle; writes visible next cycle, or same cycle when REGFILE_BYPASS_EN is defined.
// Backpressure: none; hazard/rd_busy are advisory and the controller decides whether to stall.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NUM_RD = 2,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    output logic [NUM_RD-1:0]      rd_busy,
    output logic                   hazard,
    input  logic                   iss_en,
    input  logic [AW-1:0]          iss_rd,
    input  logic                   wr0_en,
    input  logic [AW-1:0]          wr0_addr,
    input  logic [XLEN-1:0]        wr0_data,
    input  logic                   wr1_en,
    input  logic [AW-1:0]          wr1_addr,
    input  logic [XLEN-1:0]        wr1_data
);

    logic [XLEN-1:0]  mem [NREGS];
    logic [NREGS-1:0] busy;

    // Entry 0 is cleared on reset and never written, so it always reads 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++)
                mem[r] <= '0;
        end else begin
            if (wr0_en && wr0_addr != '0)
                mem[wr0_addr] <= wr0_data;
            if (wr1_en && wr1_addr != '0)
                mem[wr1_addr] <= wr1_data;
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .iss_en    (iss_en),
        .iss_rd    (iss_rd),
        .clr0_en   (wr0_en),
        .clr0_addr (wr0_addr),
        .clr1_en   (wr1_en),
        .clr1_addr (wr1_addr),
        .busy      (busy)
    );

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            bsy;

        assign addr = rd_addr[i*AW +: AW];

        always_comb begin
            data = mem[addr];
            bsy  = busy[addr];
`ifdef REGFILE_BYPASS_EN
            // A forwarded value retires the old producer unless a new one issues now.
            if (wr0_en && wr0_addr == addr && addr != '0) begin
                data = wr0_data;
                bsy  = iss_en && iss_rd == addr;
            end
            if (wr1_en && wr1_addr == addr && addr != '0) begin
                data = wr1_data;
                bsy  = iss_en && iss_rd == addr;
            end
`endif
        end

        assign rd_data[i*XLEN +: XLEN] = data;
        assign rd_busy[i]              = bsy;
    end

    assign hazard = |rd_busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed checks for regfile_mp: default instance (32 regs, 2 read ports) and RV32E instance (16 regs, 3 read ports).
// Expectations follow the build: REGFILE_BYPASS_EN changes same-cycle read results.
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst;

    // default instance
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        hazard;
    logic        iss_en;
    logic [4:0]  iss_rd;
    logic        wr0_en, wr1_en;
    logic [4:0]  wr0_addr, wr1_addr;
    logic [31:0] wr0_data, wr1_data;

    // 16-register, 3-port instance
    logic [11:0] e_rd_addr;
    logic [95:0] e_rd_data;
    logic [2:0]  e_rd_busy;
    logic        e_hazard;
    logic        e_wr0_en, e_wr1_en;
    logic [3:0]  e_wr0_addr, e_wr1_addr;
    logic [31:0] e_wr0_data, e_wr1_data;

    int n_chk = 0;
    int n_err = 0;

    regfile_mp dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .hazard   (hazard),
        .iss_en   (iss_en),
        .iss_rd   (iss_rd),
        .wr0_en   (wr0_en),
        .wr0_addr (wr0_addr),
        .wr0_data (wr0_data),
        .wr1_en   (wr1_en),
        .wr1_addr (wr1_addr),
        .wr1_data (wr1_data)
    );

    regfile_mp #(
        .XLEN   (32),
        .NREGS  (16),
        .NUM_RD (3)
    ) dut_e (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (e_rd_addr),
        .rd_data  (e_rd_data),
        .rd_busy  (e_rd_busy),
        .hazard   (e_hazard),
        .iss_en   (1'b0),
        .iss_rd   (4'd0),
        .wr0_en   (e_wr0_en),
        .wr0_addr (e_wr0_addr),
        .wr0_data (e_wr0_data),
        .wr1_en   (e_wr1_en),
        .wr1_addr (e_wr1_addr),
        .wr1_data (e_wr1_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_wr();
        wr0_en = 1'b0; wr1_en = 1'b0; iss_en = 1'b0;
        e_wr0_en = 1'b0; e_wr1_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rd_addr = '0; iss_en = 1'b0; iss_rd = '0;
        wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
        e_rd_addr = '0;
        e_wr0_en = 1'b0; e_wr0_addr = '0; e_wr0_data = '0;
        e_wr1_en = 1'b0; e_wr1_addr = '0; e_wr1_data = '0;
        #12;
        chk("reset_data", rd_data, 64'h0);
        chk("reset_hazard", {63'h0, hazard}, 64'h0);
        rst = 1'b0;

        // 1: write x5 and mark it busy, then reset between edges
        step();
        wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF;
        iss_en = 1'b1; iss_rd = 5'd5;
        rd_addr = {5'd0, 5'd5};
        step();
        idle_wr();
        #1;
        chk("t1_x5_data", {32'h0, rd_data[31:0]}, 64'hDEADBEEF);
        chk("t1_x5_busy", {63'h0, rd_busy[0]}, 64'h1);
        #1 rst = 1'b1;
        #1;
        chk("t1_rst_data", {32'h0, rd_data[31:0]}, 64'h0);
        chk("t1_rst_busy", {62'h0, rd_busy}, 64'h0);
        chk("t1_rst_hazard", {63'h0, hazard}, 64'h0);
        rst = 1'b0;

        // 2: write latency on port 0
        step();
        wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'h12345678;
        rd_addr = {5'd0, 5'd3};
        #1;
        chk("t2_same_cycle", {32'h0, rd_data[31:0]}, BYP ? 64'h12345678 : 64'h0);
        step();
        idle_wr();
        #1;
        chk("t2_next_cycle", {32'h0, rd_data[31:0]}, 64'h12345678);

        // 3: port-1 priority, and x0 stays zero
        wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h1;
        wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h2;
        rd_addr = {5'd3, 5'd7};
        #1;
        chk("t3_same_cycle", {32'h0, rd_data[31:0]}, BYP ? 64'h2 : 64'h0);
        step();
        idle_wr();
        #1;
        chk("t3_prio", {32'h0, rd_data[31:0]}, 64'h2);
        chk("t3_other_port", {32'h0, rd_data[63:32]}, 64'h12345678);
        wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hFFFFFFFF;
        wr1_en = 1'b1; wr1_addr = 5'd0; wr1_data = 32'hFFFFFFFF;
        rd_addr = {5'd0, 5'd0};
        #1;
        chk("t3_x0_same", rd_data, 64'h0);
        step();
        idle_wr();
        #1;
        chk("t3_x0_next", rd_data, 64'h0);

        // 4: scoreboard set by issue, cleared by port 1 writeback
        iss_en = 1'b1; iss_rd = 5'd9;
        rd_addr = {5'd0, 5'd9};
        #1;
        chk("t4_issue_cycle_busy", {63'h0, rd_busy[0]}, 64'h0);
        step();
        idle_wr();
        #1;
        chk("t4_busy", {63'h0, rd_busy[0]}, 64'h1);
        chk("t4_hazard", {63'h0, hazard}, 64'h1);
        wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'hAA;
        #1;
        chk("t4_wb_cycle_data", {32'h0, rd_data[31:0]}, BYP ? 64'hAA : 64'h0);
        chk("t4_wb_cycle_busy", {63'h0, rd_busy[0]}, BYP ? 64'h0 : 64'h1);
        step();
        idle_wr();
        #1;
        chk("t4_cleared_busy", {63'h0, rd_busy[0]}, 64'h0);
        chk("t4_cleared_hazard", {63'h0, hazard}, 64'h0);
        chk("t4_data", {32'h0, rd_data[31:0]}, 64'hAA);

        // 5: set beats clear; issue to x0 is ignored
        iss_en = 1'b1; iss_rd = 5'd4;
        rd_addr = {5'd4, 5'd0};
        step();
        idle_wr();
        #1;
        chk("t5_busy", {63'h0, rd_busy[1]}, 64'h1);
        iss_en = 1'b1; iss_rd = 5'd4;
        wr0_en = 1'b1; wr0_addr = 5'd4; wr0_data = 32'h55;
        #1;
        chk("t5_coll_busy_now", {63'h0, rd_busy[1]}, 64'h1);
        chk("t5_coll_data_now", {32'h0, rd_data[63:32]}, BYP ? 64'h55 : 64'h0);
        step();
        idle_wr();
        #1;
        chk("t5_still_busy", {63'h0, rd_busy[1]}, 64'h1);
        chk("t5_data", {32'h0, rd_data[63:32]}, 64'h55);
        iss_en = 1'b1; iss_rd = 5'd0;
        step();
        idle_wr();
        rd_addr = {5'd0, 5'd0};
        #1;
        chk("t5_x0_busy", {62'h0, rd_busy}, 64'h0);
        chk("t5_x0_hazard", {63'h0, hazard}, 64'h0);

        // 6: 16-register, 3-port instance
        e_wr0_en = 1'b1; e_wr0_addr = 4'd15; e_wr0_data = 32'hCAFE;
        e_wr1_en = 1'b1; e_wr1_addr = 4'd14; e_wr1_data = 32'hBEEF;
        e_rd_addr = {4'd15, 4'd15, 4'd15};
        step();
        idle_wr();
        #1;
        chk("t6_p0", {32'h0, e_rd_data[31:0]},  64'hCAFE);
        chk("t6_p1", {32'h0, e_rd_data[63:32]}, 64'hCAFE);
        chk("t6_p2", {32'h0, e_rd_data[95:64]}, 64'hCAFE);
        e_rd_addr = {4'd1, 4'd15, 4'd14};
        #1;
        chk("t6_mix_p0", {32'h0, e_rd_data[31:0]},  64'hBEEF);
        chk("t6_mix_p1", {32'h0, e_rd_data[63:32]}, 64'hCAFE);
        chk("t6_mix_p2", {32'h0, e_rd_data[95:64]}, 64'h0);
        chk("t6_hazard", {63'h0, e_hazard}, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
